// File: rtl/huff_seq_ctrl.sv
// Huffman encoder sequencer: pulls RLC symbols for a whole image, issues them to
// the encoder as DC + AC per block with the component table (mode) per block,
// flags the final symbol, then waits for the encoder output to drain.
module huff_seq_ctrl #(
  parameter int unsigned MCU_W      = 12,
  parameter int unsigned Y_BLKS_420 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fmt,
  input  logic [MCU_W-1:0] num_mcu,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             sym_is_dc,
  input  logic             sym_eob,
  input  logic [15:0]      sym_data,
  input  logic             stall,
  input  logic             out_empty,
  output logic             valid,
  output logic             DC_valid,
  output logic [11:0]      af_RLC_data_AC,
  output logic [15:0]      af_RLC_data_DC,
  output logic [1:0]       mode,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned BlkW = $clog2(Y_BLKS_420 + 2);

  typedef enum logic [2:0] {StIdle, StDc, StAc, StDrain, StFin} state_e;

  state_e           state_q, state_d;
  logic             fmt_q;
  logic [MCU_W-1:0] num_mcu_q;
  logic [MCU_W-1:0] mcu_cnt_q;
  logic [BlkW-1:0]  blk_cnt_q;
  logic [1:0]       drain_cnt_q;
  logic             err_q;
  logic             valid_q, dc_valid_q, last_q;
  logic [11:0]      ac_data_q;
  logic [15:0]      dc_data_q;
  logic [1:0]       mode_q;

  logic            xfer;
  logic            start_acc;
  logic            dc_ok, ac_ok, bad_sym;
  logic            blk_done, img_done;
  logic            last_blk;
  logic [BlkW-1:0] blk_max;
  logic [1:0]      blk_mode;

  assign xfer      = sym_valid && sym_ready;
  assign start_acc = (state_q == StIdle) && start;
  assign dc_ok     = (state_q == StDc) && xfer && sym_is_dc;
  assign ac_ok     = (state_q == StAc) && xfer && !sym_is_dc;
  assign bad_sym   = xfer && (((state_q == StDc) && !sym_is_dc) ||
                              ((state_q == StAc) && sym_is_dc));
  assign blk_max   = fmt_q ? BlkW'(Y_BLKS_420 + 1) : BlkW'(2);
  assign last_blk  = (blk_cnt_q == blk_max);
  assign blk_done  = ac_ok && sym_eob;
  // num_mcu_q is never 0 here: a zero-MCU start bypasses DC/AC entirely
  assign img_done  = blk_done && last_blk && (mcu_cnt_q == num_mcu_q - MCU_W'(1));

  // Component table for the block currently being streamed
  always_comb begin
    blk_mode = 2'b00;
    if (fmt_q) begin
      if (blk_cnt_q == BlkW'(Y_BLKS_420))     blk_mode = 2'b01;
      else if (blk_cnt_q > BlkW'(Y_BLKS_420)) blk_mode = 2'b10;
    end else begin
      if (blk_cnt_q == BlkW'(1))      blk_mode = 2'b01;
      else if (blk_cnt_q == BlkW'(2)) blk_mode = 2'b10;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (num_mcu == '0) ? StFin : StDc;
      end
      StDc: begin
        if (dc_ok) state_d = StAc;
      end
      StAc: begin
        if (img_done)      state_d = StDrain;
        else if (blk_done) state_d = StDc;
      end
      StDrain: begin
        // drain_cnt_q reaches 2 two cycles after the final strobe
        if (drain_cnt_q == 2'd2 && out_empty && !stall) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    sym_ready = ((state_q == StDc) || (state_q == StAc)) && !stall;
    busy      = (state_q == StDc) || (state_q == StAc) || (state_q == StDrain);
    done      = (state_q == StFin);
  end

  // Image context, block/MCU counters, error flag and drain timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fmt_q       <= 1'b0;
      num_mcu_q   <= '0;
      mcu_cnt_q   <= '0;
      blk_cnt_q   <= '0;
      err_q       <= 1'b0;
      drain_cnt_q <= 2'd0;
    end else begin
      if (start_acc) begin
        fmt_q     <= fmt;
        num_mcu_q <= num_mcu;
        mcu_cnt_q <= '0;
        blk_cnt_q <= '0;
        err_q     <= 1'b0;
      end else begin
        if (bad_sym) err_q <= 1'b1;
        if (blk_done) begin
          if (last_blk) begin
            blk_cnt_q <= '0;
            mcu_cnt_q <= mcu_cnt_q + MCU_W'(1);
          end else begin
            blk_cnt_q <= blk_cnt_q + BlkW'(1);
          end
        end
      end
      if (state_q != StDrain)    drain_cnt_q <= 2'd0;
      else if (drain_cnt_q != 2'd2) drain_cnt_q <= drain_cnt_q + 2'd1;
    end
  end

  // Registered encoder strobes; data and mode hold between strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      dc_valid_q <= 1'b0;
      last_q     <= 1'b0;
      ac_data_q  <= '0;
      dc_data_q  <= '0;
      mode_q     <= 2'b00;
    end else begin
      valid_q    <= ac_ok;
      dc_valid_q <= dc_ok;
      last_q     <= img_done;
      if (ac_ok) begin
        ac_data_q <= sym_data[11:0];
        mode_q    <= blk_mode;
      end
      if (dc_ok) begin
        dc_data_q <= sym_data;
        mode_q    <= blk_mode;
      end
    end
  end

  assign valid          = valid_q;
  assign DC_valid       = dc_valid_q;
  assign last           = last_q;
  assign af_RLC_data_AC = ac_data_q;
  assign af_RLC_data_DC = dc_data_q;
  assign mode           = mode_q;
  assign err            = err_q;

endmodule

// File: tb/tb_huff_seq_ctrl.sv
// Self-checking bench for huff_seq_ctrl: a scoreboard of expected encoder strobes
// is filled as symbols are handed over and drained by a monitor on the falling edge.
module tb_huff_seq_ctrl;

  localparam int unsigned MCU_W = 12;
  localparam int unsigned YB    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, fmt;
  logic [MCU_W-1:0] num_mcu;
  logic             sym_valid, sym_ready, sym_is_dc, sym_eob;
  logic [15:0]      sym_data;
  logic             stall, out_empty;
  logic             valid, DC_valid, last, busy, done, err;
  logic [11:0]      af_RLC_data_AC;
  logic [15:0]      af_RLC_data_DC;
  logic [1:0]       mode;

  typedef struct {
    logic        dc;
    logic [15:0] data;
    logic [1:0]  mode;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   strobes  = 0;
  int   done_cnt = 0;
  int   cyc      = 0;
  int   last_cyc = 0;
  bit   had_last = 0;

  always #5 clk = ~clk;

  huff_seq_ctrl #(.MCU_W(MCU_W), .Y_BLKS_420(YB)) dut (
    .clk(clk), .rst(rst), .start(start), .fmt(fmt), .num_mcu(num_mcu),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_is_dc(sym_is_dc),
    .sym_eob(sym_eob), .sym_data(sym_data), .stall(stall), .out_empty(out_empty),
    .valid(valid), .DC_valid(DC_valid), .af_RLC_data_AC(af_RLC_data_AC),
    .af_RLC_data_DC(af_RLC_data_DC), .mode(mode), .last(last), .busy(busy),
    .done(done), .err(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_mode(input logic f, input int blk);
    if (f) return (blk < YB) ? 2'b00 : (blk == YB) ? 2'b01 : 2'b10;
    return 2'(blk);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (valid || DC_valid) begin
        strobes++;
        if (valid && DC_valid) check_eq("dual_strobe", 1, 0);
        if (sb.size() == 0) begin
          check_eq("unexpected_strobe", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("strobe_kind", {31'd0, DC_valid}, {31'd0, e.dc});
          if (e.dc) check_eq("dc_data", {16'd0, af_RLC_data_DC}, {16'd0, e.data});
          else      check_eq("ac_data", {20'd0, af_RLC_data_AC}, {20'd0, e.data[11:0]});
          check_eq("mode", {30'd0, mode}, {30'd0, e.mode});
          check_eq("last", {31'd0, last}, {31'd0, e.last});
          if (e.last) begin
            had_last = 1;
            last_cyc = cyc;
          end
        end
      end
      if (done) begin
        done_cnt++;
        if (had_last) check_eq("drain_gap", {31'd0, (cyc - last_cyc) >= 2}, 1);
        had_last = 0;
      end
    end
  end

  task automatic pulse_start(input logic f, input int n);
    @(posedge clk); #1;
    start = 1'b1; fmt = f; num_mcu = MCU_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one symbol and hold it until accepted; optionally expect it at the encoder
  task automatic send_sym(input logic dc, input logic eob, input bit expect_it,
                          input logic [1:0] em, input logic el);
    logic [15:0] d;
    bit ok;
    exp_t e;
    d = 16'($urandom);
    sym_valid = 1'b1; sym_is_dc = dc; sym_eob = eob; sym_data = d;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sym_ready) begin
        ok = 1;
        if (expect_it) begin
          e.dc = dc; e.data = d; e.mode = em; e.last = el;
          sb.push_back(e);
        end
        break;
      end
    end
    if (!ok) check_eq("ready_timeout", 0, 1);
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check_eq("done_seen", {31'd0, seen}, 1);
  endtask

  // Full image: bad=1 injects an AC-in-DC and a DC-in-AC symbol in the first block
  task automatic run_image(input logic f, input int n, input int nac, input bit bad);
    int nblk;
    int d0;
    nblk = f ? YB + 2 : 3;
    d0 = done_cnt;
    out_empty = 1'b0;
    pulse_start(f, n);
    @(negedge clk);
    check_eq("busy_after_start", {31'd0, busy}, 1);
    check_eq("err_cleared", {31'd0, err}, 0);
    for (int m = 0; m < n; m++) begin
      for (int b = 0; b < nblk; b++) begin
        if (bad && m == 0 && b == 0) begin
          send_sym(1'b0, 1'b0, 0, 2'b00, 1'b0);
          @(negedge clk);
          check_eq("err_ac_in_dc", {31'd0, err}, 1);
        end
        send_sym(1'b1, 1'b0, 1, exp_mode(f, b), 1'b0);
        if (bad && m == 0 && b == 0) send_sym(1'b1, 1'b0, 0, 2'b00, 1'b0);
        if (f && m == 0 && b == 1) pulse_start(1'b0, 0);  // ignored while busy
        for (int k = 0; k < nac; k++)
          send_sym(1'b0, k == nac - 1, 1, exp_mode(f, b),
                   (m == n - 1) && (b == nblk - 1) && (k == nac - 1));
      end
    end
    repeat (4) @(negedge clk);
    check_eq("drain_busy", {31'd0, busy}, 1);
    check_eq("drain_ready", {31'd0, sym_ready}, 0);
    pulse_start(1'b0, 5);  // start during drain has no effect
    repeat (2) @(negedge clk);
    check_eq("drain_holds", done_cnt, d0);
    out_empty = 1'b1;
    wait_done();
    out_empty = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_after_done", {31'd0, busy}, 0);
    check_eq("done_once", done_cnt, d0 + 1);
    check_eq("sb_empty", sb.size(), 0);
    if (bad) check_eq("err_sticky", {31'd0, err}, 1);
  endtask

  initial begin
    int s0, d0, s1;
    rst = 1'b0; start = 1'b0; fmt = 1'b0; num_mcu = '0;
    sym_valid = 1'b0; sym_is_dc = 1'b0; sym_eob = 1'b0; sym_data = '0;
    stall = 1'b0; out_empty = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {22'd0, valid, DC_valid, last, busy, done, err, sym_ready,
                             mode, 1'b0}, 0);
    rst = 1'b1;

    // Single MCU 4:4:4, three symbols per block
    s0 = strobes;
    run_image(1'b0, 1, 2, 0);
    check_eq("strobes_444", strobes - s0, 9);

    // Two MCUs 4:2:0, DC + EOB per block, with a start pulse mid-image
    s0 = strobes;
    run_image(1'b1, 2, 1, 0);
    check_eq("strobes_420", strobes - s0, 24);

    // Back-pressure: 5 stall cycles mid-block
    s0 = strobes;
    fork
      run_image(1'b0, 1, 4, 0);
      begin
        for (int i = 0; i < 200 && strobes < s0 + 3; i++) @(posedge clk);
        @(posedge clk); #1;
        stall = 1'b1;
        @(posedge clk); #1;
        s1 = strobes;
        repeat (4) begin
          @(negedge clk);
          check_eq("stall_ready", {31'd0, sym_ready}, 0);
          @(posedge clk);
        end
        #1 stall = 1'b0;
        @(negedge clk);
        check_eq("stall_release_ready", {31'd0, sym_ready}, 1);
        @(posedge clk); #1;
        check_eq("stall_no_strobe", strobes, s1);
        @(posedge clk); #1;
        check_eq("stall_resume", strobes, s1 + 1);
      end
    join
    check_eq("strobes_stall", strobes - s0, 15);

    // Protocol errors; the following start clears err (checked in run_image)
    run_image(1'b0, 1, 1, 1);

    // Zero-MCU image: done with no strobes
    s0 = strobes; d0 = done_cnt;
    pulse_start(1'b0, 0);
    repeat (4) @(negedge clk);
    check_eq("zero_done", done_cnt, d0 + 1);
    check_eq("zero_strobes", strobes, s0);
    check_eq("zero_err_cleared", {31'd0, err}, 0);

    // Reset mid-AC, then a fresh image
    out_empty = 1'b0;
    pulse_start(1'b1, 2);
    send_sym(1'b1, 1'b0, 1, 2'b00, 1'b0);
    send_sym(1'b0, 1'b0, 1, 2'b00, 1'b0);
    @(negedge clk);
    d0 = done_cnt;
    #1 rst = 1'b0;
    #1;
    check_eq("rst_mid_outputs", {22'd0, valid, DC_valid, last, busy, done, err, sym_ready,
                                 mode, 1'b0}, 0);
    sb.delete();
    had_last = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_no_done", done_cnt, d0);
    s0 = strobes;
    run_image(1'b1, 1, 2, 0);
    check_eq("strobes_after_rst", strobes - s0, 18);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
